// File: rtl/mac_out_collector.sv
// rtl/mac_out_collector.sv - ping-pong tile collector for skewed systolic psum rows
// Optional feature: define MAC_OUT_RELU_EN to clamp negative output lanes to zero.
module mac_out_collector #(
    parameter int VEC_PER_TILE = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLR,
    input  logic [63:0] ODATA,
    input  logic [3:0]  OVALID,
    output logic [63:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_LAST,
    output logic        OVF,
    output logic        BUSY
);

    localparam int CW = (VEC_PER_TILE > 1) ? $clog2(VEC_PER_TILE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(VEC_PER_TILE - 1);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    logic [15:0]   mem [2][VEC_PER_TILE][4];
    logic [1:0]    bstate [2];
    logic [3:0]    done [2];
    logic [3:0]    done_nxt [2];
    logic [1:0]    bank_wr;
    logic [CW-1:0] cnt [4];
    logic [3:0]    bsel;
    logic          dsel;
    logic [CW-1:0] beat;

    logic [3:0]    wr_ok;
    logic [3:0]    wr_drop;
    logic [3:0]    row_done;
    logic          xfer;
    logic [1:0]    cur_state;
    logic [63:0]   rd_data;

    // A row may only write into a bank that is not holding a finished tile.
    always_comb begin
        wr_ok    = '0;
        wr_drop  = '0;
        row_done = '0;
        for (int r = 0; r < 4; r++) begin
            if (OVALID[r]) begin
                if (bstate[bsel[r]] == ST_EMPTY || bstate[bsel[r]] == ST_FILLING) begin
                    wr_ok[r]    = 1'b1;
                    row_done[r] = (cnt[r] == LAST_IDX);
                end else begin
                    wr_drop[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bank_wr = '0;
        for (int b = 0; b < 2; b++) begin
            done_nxt[b] = done[b];
        end
        for (int r = 0; r < 4; r++) begin
            if (wr_ok[r]) begin
                bank_wr[bsel[r]] = 1'b1;
                if (row_done[r]) begin
                    done_nxt[bsel[r]][r] = 1'b1;
                end
            end
        end
    end

    assign cur_state = bstate[dsel];
    assign OUT_VALID = (cur_state == ST_FULL) || (cur_state == ST_DRAINING);
    assign xfer      = OUT_VALID && OUT_READY;
    assign OUT_LAST  = OUT_VALID && (beat == LAST_IDX);

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < 4; r++) begin
`ifdef MAC_OUT_RELU_EN
            rd_data[63-r*16 -: 16] = mem[dsel][beat][r][15] ? 16'd0 : mem[dsel][beat][r];
`else
            rd_data[63-r*16 -: 16] = mem[dsel][beat][r];
`endif
        end
    end

    // Gating on OUT_VALID keeps uninitialised storage off the bus.
    assign OUT_DATA = OUT_VALID ? rd_data : 64'd0;

    always_comb begin
        BUSY = (bstate[0] != ST_EMPTY) || (bstate[1] != ST_EMPTY);
        for (int r = 0; r < 4; r++) begin
            if (cnt[r] != '0) begin
                BUSY = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && !CLR) begin
            for (int r = 0; r < 4; r++) begin
                if (wr_ok[r]) begin
                    mem[bsel[r]][cnt[r]][r] <= ODATA[63-r*16 -: 16];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            for (int b = 0; b < 2; b++) begin
                bstate[b] <= ST_EMPTY;
                done[b]   <= '0;
            end
            for (int r = 0; r < 4; r++) begin
                cnt[r] <= '0;
            end
            bsel <= '0;
            dsel <= 1'b0;
            beat <= '0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                if (wr_ok[r]) begin
                    if (row_done[r]) begin
                        cnt[r]  <= '0;
                        bsel[r] <= ~bsel[r];
                    end else begin
                        cnt[r] <= cnt[r] + 1'b1;
                    end
                end
            end
            // Drain and fill never target the same bank: their states are exclusive.
            for (int b = 0; b < 2; b++) begin
                if (xfer && dsel == 1'(b)) begin
                    if (beat == LAST_IDX) begin
                        bstate[b] <= ST_EMPTY;
                        done[b]   <= '0;
                    end else begin
                        bstate[b] <= ST_DRAINING;
                    end
                end else if (bank_wr[b]) begin
                    done[b]   <= done_nxt[b];
                    bstate[b] <= (&done_nxt[b]) ? ST_FULL : ST_FILLING;
                end
            end
            if (xfer) begin
                if (beat == LAST_IDX) begin
                    beat <= '0;
                    dsel <= ~dsel;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (!CLR && (|wr_drop)) begin
            OVF <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_out_collector.sv
// tb/tb_mac_out_collector.sv - directed self-checking bench for mac_out_collector
module tb_mac_out_collector;

    logic        CLK;
    logic        RST;
    logic        CLR;
    logic [63:0] ODATA;
    logic [3:0]  OVALID;
    logic [63:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic        OVF;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    mac_out_collector #(.VEC_PER_TILE(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLR       (CLR),
        .ODATA     (ODATA),
        .OVALID    (OVALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] base, input int k);
        pk = {base + 16'(16*k), base + 16'(16*k + 1), base + 16'(16*k + 2), base + 16'(16*k + 3)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; CLR = 1'b0; OVALID = '0; ODATA = '0; OUT_READY = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic fill(input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            OVALID = 4'hF;
            ODATA  = pk(base, k);
            step();
        end
        OVALID = '0;
        ODATA  = '0;
    endtask

    // Tile t of a multi-tile drain uses base + 0x100*t.
    task automatic drain(input logic [15:0] base, input int nb, input bit strict);
        OUT_READY = 1'b1;
        for (int k = 0; k < nb; k++) begin
            int w = 0;
            if (!strict) begin
                while (!OUT_VALID && w < 20) begin
                    step();
                    w++;
                end
            end
            check("beat_valid", 64'(OUT_VALID), 64'd1);
            check("beat_data", OUT_DATA, pk(base + 16'(16'h100 * (k / 4)), k % 4));
            check("beat_last", 64'(OUT_LAST), 64'((k % 4) == 3));
            step();
        end
        OUT_READY = 1'b0;
    endtask

    initial begin
        RST = 1'b1; CLR = 1'b0; OVALID = '0; ODATA = '0; OUT_READY = 1'b0;
        step();
        step();
        RST = 1'b0;
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_last",  64'(OUT_LAST),  64'd0);
        check("rst_data",  OUT_DATA,       64'd0);
        check("rst_ovf",   64'(OVF),       64'd0);
        check("rst_busy",  64'(BUSY),      64'd0);

        // Aligned fill: valid must not appear before the fourth write.
        for (int k = 0; k < 4; k++) begin
            OVALID = 4'hF;
            ODATA  = pk(16'h0, k);
            step();
            if (k == 2) check("aligned_early_valid", 64'(OUT_VALID), 64'd0);
        end
        OVALID = '0;
        ODATA  = '0;
        drain(16'h0, 4, 1'b1);
        check("aligned_idle_valid", 64'(OUT_VALID), 64'd0);
        check("aligned_idle_busy",  64'(BUSY),      64'd0);

        // Systolic skew: row r starts r cycles late.
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 4; r++) begin
                OVALID[r] = (c >= r) && (c - r < 4);
                ODATA[63-r*16 -: 16] = 16'(16 * (c - r) + r);
            end
            step();
            if (c == 5) check("skew_early_valid", 64'(OUT_VALID), 64'd0);
        end
        OVALID = '0;
        ODATA  = '0;
        drain(16'h0, 4, 1'b1);

        // Backpressure: both banks full, ninth psum is dropped.
        OUT_READY = 1'b0;
        fill(16'h100);
        fill(16'h200);
        check("bp_ovf_before", 64'(OVF), 64'd0);
        OVALID = 4'b0001;
        ODATA  = 64'hDEAD_0000_0000_0000;
        step();
        OVALID = '0;
        ODATA  = '0;
        check("bp_ovf_set", 64'(OVF), 64'd1);
        check("bp_hold_data0", OUT_DATA, pk(16'h100, 0));
        step();
        check("bp_hold_data1", OUT_DATA, pk(16'h100, 0));
        check("bp_hold_last",  64'(OUT_LAST), 64'd0);
        drain(16'h100, 8, 1'b1);
        check("bp_idle_busy", 64'(BUSY), 64'd0);

        // CLR mid-tile; OVALID during CLR is ignored.
        do_reset();
        OVALID = 4'b0001;
        ODATA  = 64'h1111_0000_0000_0000;
        step();
        step();
        OVALID = '0;
        check("clr_busy_before", 64'(BUSY), 64'd1);
        CLR    = 1'b1;
        OVALID = 4'hF;
        step();
        CLR    = 1'b0;
        OVALID = '0;
        ODATA  = '0;
        check("clr_busy_after",  64'(BUSY),      64'd0);
        check("clr_valid_after", 64'(OUT_VALID), 64'd0);
        fill(16'h300);
        drain(16'h300, 4, 1'b1);
        check("clr_ovf", 64'(OVF), 64'd0);

        // Negative lane, then reset while draining beat 2.
        do_reset();
        OVALID = 4'hF;
        ODATA  = {16'd0, 16'hFF38, 16'd2, 16'd3};
        step();
        for (int k = 1; k < 4; k++) begin
            ODATA = pk(16'h0, k);
            step();
        end
        OVALID = '0;
        ODATA  = '0;
        OUT_READY = 1'b1;
`ifdef MAC_OUT_RELU_EN
        check("relu_beat0", OUT_DATA, {16'd0, 16'd0, 16'd2, 16'd3});
`else
        check("relu_beat0", OUT_DATA, {16'd0, 16'hFF38, 16'd2, 16'd3});
`endif
        step();
        check("relu_beat1", OUT_DATA, pk(16'h0, 1));
        step();
        check("drain_beat2_valid", 64'(OUT_VALID), 64'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        OUT_READY = 1'b0;
        check("rst_drain_valid", 64'(OUT_VALID), 64'd0);
        check("rst_drain_ovf",   64'(OVF),       64'd0);
        check("rst_drain_busy",  64'(BUSY),      64'd0);
        check("rst_drain_data",  OUT_DATA,       64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
